mult_div_unit: RTL and testbench

- Iterative multiply/divide unit beside the single-cycle datapath's combinational ALU.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles and holds results in the architectural HI/LO registers.
- Supports MTHI/MTLO writes.
- The controller starts an operation with a one-cycle `start` pulse, stalls the PC while `busy` is high, and reads `hi`/`lo` for MFHI/MFLO.

---
 rtl/mult_div_unit.sv | 246 ++++++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit holding the architectural HI/LO registers.
// Divider datapath is present only when MDU_DIV_EN is defined; otherwise divide ops are ignored.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] ln1,
    input  logic [WIDTH-1:0] ln2,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [DW-1:0] neg_dw(input logic [DW-1:0] v);
        return ~v + DW'(1);
    endfunction

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             start_ok;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [DW-1:0]    mul_next;

`ifdef MDU_DIV_EN
    logic             is_div_q, is_div_d;
    logic             rneg_q, rneg_d;
    logic             zdiv_q, zdiv_d;
    logic [WIDTH-1:0] orig_q, orig_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [DW-1:0]    div_next;
`endif

    // Next-state, datapath step and HI/LO update logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
`ifdef MDU_DIV_EN
        is_div_d = is_div_q;
        rneg_d   = rneg_q;
        zdiv_d   = zdiv_q;
        orig_d   = orig_q;
        dbz_d    = dbz_q;
        start_ok = start;
`else
        start_ok = start & ~op[1];
`endif

        a_neg = op[0] & ln1[WIDTH-1];
        b_neg = op[0] & ln2[WIDTH-1];
        a_mag = a_neg ? neg_w(ln1) : ln1;
        b_mag = b_neg ? neg_w(ln2) : ln2;

        // Shift-add: the carry out of the upper half re-enters as the new MSB.
        mul_sum  = {1'b0, acc_q[DW-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef MDU_DIV_EN
        div_shift = acc_q[DW-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        if (div_diff[WIDTH]) begin
            div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
`endif

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_RUN;
                    cnt_d   = {CW{1'b0}};
                    neg_d   = a_neg ^ b_neg;
                    acc_d   = {{WIDTH{1'b0}}, b_mag};
                    opnd_d  = a_mag;
`ifdef MDU_DIV_EN
                    is_div_d = op[1];
                    rneg_d   = a_neg;
                    zdiv_d   = (ln2 == {WIDTH{1'b0}});
                    orig_d   = ln1;
                    if (op[1]) begin
                        acc_d  = {{WIDTH{1'b0}}, a_mag};
                        opnd_d = b_mag;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, b_mag};
                        opnd_d = a_mag;
                    end
`endif
                end else begin
                    if (hi_we) begin
                        hi_d = wdata;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (lo_we) begin
                        lo_d = wdata;
                    end else begin
                        lo_d = lo_q;
                    end
                end
            end
            S_RUN: begin
                acc_d = mul_next;
`ifdef MDU_DIV_EN
                if (is_div_q) begin
                    acc_d = div_next;
                end else begin
                    acc_d = mul_next;
                end
`endif
                if (cnt_q == LAST_STEP) begin
                    state_d = S_FIX;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FIX: begin
                // First FIX cycle folds the sign correction into acc; the second commits it.
                if (cnt_q == {CW{1'b0}}) begin
                    cnt_d = CW'(1);
                    acc_d = neg_q ? neg_dw(acc_q) : acc_q;
`ifdef MDU_DIV_EN
                    if (is_div_q) begin
                        if (zdiv_q) begin
                            acc_d = {orig_q, {WIDTH{1'b1}}};
                        end else begin
                            acc_d = {(rneg_q ? neg_w(acc_q[DW-1:WIDTH]) : acc_q[DW-1:WIDTH]),
                                     (neg_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0])};
                        end
                    end else begin
                        acc_d = neg_q ? neg_dw(acc_q) : acc_q;
                    end
`endif
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = {CW{1'b0}};
                    hi_d    = acc_q[DW-1:WIDTH];
                    lo_d    = acc_q[WIDTH-1:0];
                    done_d  = 1'b1;
`ifdef MDU_DIV_EN
                    if (is_div_q) begin
                        dbz_d = zdiv_q;
                    end else begin
                        dbz_d = dbz_q;
                    end
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CW{1'b0}};
            acc_q    <= {DW{1'b0}};
            opnd_q   <= {WIDTH{1'b0}};
            neg_q    <= 1'b0;
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MDU_DIV_EN
            is_div_q <= 1'b0;
            rneg_q   <= 1'b0;
            zdiv_q   <= 1'b0;
            orig_q   <= {WIDTH{1'b0}};
            dbz_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef MDU_DIV_EN
            is_div_q <= is_div_d;
            rneg_q   <= rneg_d;
            zdiv_q   <= zdiv_d;
            orig_q   <= orig_d;
            dbz_q    <= dbz_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
`ifdef MDU_DIV_EN
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (WIDTH=32); divide checks follow MDU_DIV_EN.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] ln1;
    logic [31:0] ln2;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int errors;
    int checks;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .ln1         (ln1),
        .ln2         (ln2),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive a one-cycle start; returns just after the accepting edge (k=0).
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        prev_hi = hi;
        prev_lo = lo;
        op    = o;
        ln1   = a;
        ln2   = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done, checking mid-run hold and the 34-cycle latency.
    task automatic wait_done(input int k0, input string tag);
        int lat;
        lat = -1;
        for (int k = k0 + 1; k <= 40 && lat < 0; k++) begin
            @(negedge clk);
            if (k == 16) begin
                chk({tag, "_busy_mid"}, {31'd0, busy}, 32'd1);
                chk({tag, "_hi_hold"}, hi, prev_hi);
                chk({tag, "_lo_hold"}, lo, prev_lo);
            end
            if (k == 33) begin
                chk({tag, "_done_early"}, {31'd0, done}, 32'd0);
            end
            if (done === 1'b1) begin
                lat = k;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'd34);
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int dcount;
        logic [1:0] rst_op;
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        ln1    = 32'd0;
        ln2    = 32'd0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        wdata  = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        reset = 1'b0;

        start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_busy_k0", {31'd0, busy}, 32'd1);
        wait_done(0, "multu_ff");
        chk("multu_ff_hi", hi, 32'hFFFF_FFFE);
        chk("multu_ff_lo", lo, 32'h0000_0001);

        start_op(2'b01, 32'hFFFF_FFFD, 32'd5);
        repeat (5) @(negedge clk);
        ln1 = 32'h1234_5678;
        wait_done(5, "mult_neg");
        chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
        chk("mult_neg_lo", lo, 32'hFFFF_FFF1);

        // IDLE register writes.
        @(negedge clk);
        lo_we = 1'b1;
        wdata = 32'h0000_1234;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo_lo", lo, 32'h0000_1234);
        chk("mtlo_done", {31'd0, done}, 32'd0);
        hi_we = 1'b1;
        wdata = 32'hCAFE_0001;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi_hi", hi, 32'hCAFE_0001);

        // start and lo_we during busy are both dropped.
        start_op(2'b00, 32'h0001_0000, 32'h0001_0000);
        repeat (10) @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        ln1   = 32'd5;
        lo_we = 1'b1;
        wdata = 32'h0000_1234;
        @(negedge clk);
        start = 1'b0;
        lo_we = 1'b0;
        wait_done(11, "busy_rule");
        chk("busy_rule_hi", hi, 32'h0000_0001);
        chk("busy_rule_lo", lo, 32'h0000_0000);
        repeat (3) @(negedge clk);
        chk("busy_rule_no_restart", {31'd0, busy}, 32'd0);

`ifdef MDU_DIV_EN
        start_op(2'b11, 32'hFFFF_FFF9, 32'd2);
        wait_done(0, "div_m7");
        chk("div_m7_lo", lo, 32'hFFFF_FFFD);
        chk("div_m7_hi", hi, 32'hFFFF_FFFF);

        start_op(2'b11, 32'd7, 32'hFFFF_FFFE);
        wait_done(0, "div_7m2");
        chk("div_7m2_lo", lo, 32'hFFFF_FFFD);
        chk("div_7m2_hi", hi, 32'd1);

        start_op(2'b10, 32'd100, 32'd7);
        wait_done(0, "divu_100");
        chk("divu_100_lo", lo, 32'd14);
        chk("divu_100_hi", hi, 32'd2);

        start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(0, "div_ovf");
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'd0);

        start_op(2'b10, 32'h0000_0064, 32'd0);
        wait_done(0, "divu_z");
        chk("divu_z_hi", hi, 32'h0000_0064);
        chk("divu_z_lo", lo, 32'hFFFF_FFFF);
        chk("divu_z_flag", {31'd0, div_by_zero}, 32'd1);

        start_op(2'b00, 32'd2, 32'd3);
        wait_done(0, "mul_keep");
        chk("mul_keep_lo", lo, 32'd6);
        chk("mul_keep_flag", {31'd0, div_by_zero}, 32'd1);

        start_op(2'b10, 32'd8, 32'd2);
        wait_done(0, "divu_8");
        chk("divu_8_lo", lo, 32'd4);
        chk("divu_8_hi", hi, 32'd0);
        chk("divu_8_flag", {31'd0, div_by_zero}, 32'd0);
        rst_op = 2'b11;
`else
        // Divides are ignored when the divider is not built.
        start_op(2'b10, 32'd100, 32'd7);
        chk("nodiv_busy", {31'd0, busy}, 32'd0);
        dcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) begin
                dcount++;
            end
        end
        chk("nodiv_no_activity", 32'(dcount), 32'd0);
        chk("nodiv_hi", hi, 32'h0000_0001);
        chk("nodiv_lo", lo, 32'h0000_0000);
        chk("nodiv_flag", {31'd0, div_by_zero}, 32'd0);
        rst_op = 2'b00;
`endif

        // Reset in the middle of an operation.
        start_op(rst_op, 32'hFFFF_FFF9, 32'd2);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        dcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dcount++;
            end
        end
        chk("midrst_no_done", 32'(dcount), 32'd0);

        // Fresh MULTU with an MTHI in the same start cycle: start wins.
        @(negedge clk);
        prev_hi = hi;
        prev_lo = lo;
        op    = 2'b00;
        ln1   = 32'd6;
        ln2   = 32'd7;
        start = 1'b1;
        hi_we = 1'b1;
        wdata = 32'h0000_DEAD;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        chk("start_wins_hi", hi, 32'd0);
        wait_done(0, "multu_42");
        chk("multu_42_lo", lo, 32'd42);
        chk("multu_42_hi", hi, 32'd0);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
